// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM channel sequencer: FSM states, grant ids,
// default timing parameters and the PI byte-lane helper.
package mem_arb_pkg;

   localparam int ARB_ACC_CYC = 4;
   localparam int ARB_MD_MAX  = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ACC  = 2'd1,
      ARB_REC  = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_GNT_MD = 1'b0,
      ARB_GNT_PI = 1'b1
   } arb_gnt_e;

   // 68k byte order: an even address is the high byte of the word.
   function automatic logic [7:0] pi_byte(input logic [15:0] word, input logic a0);
      return a0 ? word[7:0] : word[15:8];
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the SRAM channel plus the MD streak counter that
// eventually forces a grant to a waiting PI requester.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MD_MAX = ARB_MD_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_req,
   input  logic pi_req,
   input  logic idle,
   input  logic grant,
   output logic winner
);

   localparam int SW = $clog2(MD_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MD_MAX);

   logic [SW-1:0] streak_q;
   logic          forcePi;

   assign forcePi = pi_req && (streak_q == STREAK_MAX);
   assign winner  = (md_req && !forcePi) ? ARB_GNT_MD : ARB_GNT_PI;

   // Streak only grows while PI is actually waiting; any relief for PI resets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else if (idle && !pi_req) begin
         streak_q <= '0;
      end else if (grant) begin
         if (winner == ARB_GNT_PI) begin
            streak_q <= '0;
         end else if (streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Two-port sequencer sharing one 16-bit async SRAM channel between the MD
// bus (word access) and the PI/MCU side (byte access), with fixed timing.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ACC_CYC = ARB_ACC_CYC,
   parameter int MD_MAX  = ARB_MD_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        md_req,
   input  logic [22:0] md_addr,
   input  logic        md_we_lo,
   input  logic        md_we_hi,
   input  logic [15:0] md_wdata,
   output logic        md_ack,
   output logic [15:0] md_rdata,
   input  logic        pi_req,
   input  logic [22:0] pi_addr,
   input  logic        pi_we,
   input  logic [7:0]  pi_wdata,
   output logic        pi_ack,
   output logic [7:0]  pi_rdata,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_di,
   output logic        mem_oe,
   output logic        mem_we_lo,
   output logic        mem_we_hi,
   input  logic [15:0] mem_do,
   output logic        busy
);

   localparam int CW = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(ACC_CYC - 1);
   localparam logic [CW-1:0] CNT_WE_OFF = CW'(ACC_CYC - 2);

   arb_state_e    state_q;
   arb_gnt_e      gnt_q;
   logic [CW-1:0] cnt_q;
   logic [22:0]   mem_addr_q;
   logic [15:0]   mem_di_q;
   logic          mem_oe_q;
   logic          mem_we_lo_q;
   logic          mem_we_hi_q;
   logic          md_ack_q;
   logic          pi_ack_q;
   logic [15:0]   md_rdata_q;
   logic [7:0]    pi_rdata_q;
   logic          busy_q;

   logic idle;
   logic grant;
   logic winner;
   logic md_wr;

   assign idle  = (state_q == ARB_IDLE);
   assign grant = idle && (md_req || pi_req);
   assign md_wr = md_we_lo || md_we_hi;

   mem_arb_pick #(
      .MD_MAX (MD_MAX)
   ) u_pick (
      .clk    (clk),
      .rst_n  (rst_n),
      .md_req (md_req),
      .pi_req (pi_req),
      .idle   (idle),
      .grant  (grant),
      .winner (winner)
   );

   // Strobes are raised on the grant edge so the first ACC cycle already drives
   // the SRAM; write strobes drop one cycle early to give data hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         gnt_q       <= ARB_GNT_MD;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_di_q    <= '0;
         mem_oe_q    <= 1'b0;
         mem_we_lo_q <= 1'b0;
         mem_we_hi_q <= 1'b0;
         md_ack_q    <= 1'b0;
         pi_ack_q    <= 1'b0;
         md_rdata_q  <= '0;
         pi_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         md_ack_q <= 1'b0;
         pi_ack_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (grant) begin
                  state_q <= ARB_ACC;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  gnt_q   <= arb_gnt_e'(winner);
                  if (winner == ARB_GNT_MD) begin
                     mem_addr_q  <= md_addr;
                     mem_di_q    <= md_wdata;
                     mem_oe_q    <= !md_wr;
                     mem_we_lo_q <= md_we_lo;
                     mem_we_hi_q <= md_we_hi;
                  end else begin
                     mem_addr_q  <= pi_addr;
                     mem_di_q    <= {pi_wdata, pi_wdata};
                     mem_oe_q    <= !pi_we;
                     mem_we_lo_q <= pi_we && pi_addr[0];
                     mem_we_hi_q <= pi_we && !pi_addr[0];
                  end
               end
            end
            ARB_ACC: begin
               if (cnt_q == CNT_LAST) begin
                  state_q     <= ARB_REC;
                  mem_oe_q    <= 1'b0;
                  mem_we_lo_q <= 1'b0;
                  mem_we_hi_q <= 1'b0;
                  md_ack_q    <= (gnt_q == ARB_GNT_MD);
                  pi_ack_q    <= (gnt_q == ARB_GNT_PI);
                  if (mem_oe_q) begin
                     if (gnt_q == ARB_GNT_MD) begin
                        md_rdata_q <= mem_do;
                     end else begin
                        pi_rdata_q <= pi_byte(mem_do, mem_addr_q[0]);
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_WE_OFF) begin
                     mem_we_lo_q <= 1'b0;
                     mem_we_hi_q <= 1'b0;
                  end
               end
            end
            ARB_REC: begin
               state_q <= ARB_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ARB_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_di    = mem_di_q;
   assign mem_oe    = mem_oe_q;
   assign mem_we_lo = mem_we_lo_q;
   assign mem_we_hi = mem_we_hi_q;
   assign md_ack    = md_ack_q;
   assign pi_ack    = pi_ack_q;
   assign md_rdata  = md_rdata_q;
   assign pi_rdata  = pi_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a table of single transactions plus hand-written
// sequences for reset, MD/PI fairness and back-to-back handshakes.
module tb_mem_arb;

   localparam int ACC_CYC = 4;
   localparam int MD_MAX  = 8;
   localparam int PERIOD  = ACC_CYC + 2;

   logic        clk;
   logic        rst_n;
   logic        md_req;
   logic [22:0] md_addr;
   logic        md_we_lo;
   logic        md_we_hi;
   logic [15:0] md_wdata;
   logic        md_ack;
   logic [15:0] md_rdata;
   logic        pi_req;
   logic [22:0] pi_addr;
   logic        pi_we;
   logic [7:0]  pi_wdata;
   logic        pi_ack;
   logic [7:0]  pi_rdata;
   logic [22:0] mem_addr;
   logic [15:0] mem_di;
   logic        mem_oe;
   logic        mem_we_lo;
   logic        mem_we_hi;
   logic [15:0] mem_do;
   logic        busy;

   int nChecks;
   int nFails;

   logic [15:0] expMdRdata;
   logic [7:0]  expPiRdata;

   typedef struct {
      string       name;
      logic        isMd;
      logic [22:0] addr;
      logic        mdWeLo;
      logic        mdWeHi;
      logic        piWe;
      logic [15:0] wdata;
      logic [15:0] memDo;
      logic        chkDi;
      logic [15:0] expDi;
      logic        expOe;
      logic        expWeLo;
      logic        expWeHi;
      logic [15:0] expRdata;
   } txn_t;

   txn_t tbl[9];

   mem_arb #(
      .ACC_CYC (ACC_CYC),
      .MD_MAX  (MD_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .md_req    (md_req),
      .md_addr   (md_addr),
      .md_we_lo  (md_we_lo),
      .md_we_hi  (md_we_hi),
      .md_wdata  (md_wdata),
      .md_ack    (md_ack),
      .md_rdata  (md_rdata),
      .pi_req    (pi_req),
      .pi_addr   (pi_addr),
      .pi_we     (pi_we),
      .pi_wdata  (pi_wdata),
      .pi_ack    (pi_ack),
      .pi_rdata  (pi_rdata),
      .mem_addr  (mem_addr),
      .mem_di    (mem_di),
      .mem_oe    (mem_oe),
      .mem_we_lo (mem_we_lo),
      .mem_we_hi (mem_we_hi),
      .mem_do    (mem_do),
      .busy      (busy)
   );

   // Free-running 100 MHz-style clock; outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One full transaction from request to the idle cycle after ack; the
   // requester drops its request on the edge that samples the ack.
   task automatic applyStimulus(input txn_t v);
      @(negedge clk);
      mem_do = v.memDo;
      if (v.isMd) begin
         md_req   = 1'b1;
         md_addr  = v.addr;
         md_we_lo = v.mdWeLo;
         md_we_hi = v.mdWeHi;
         md_wdata = v.wdata;
      end else begin
         pi_req   = 1'b1;
         pi_addr  = v.addr;
         pi_we    = v.piWe;
         pi_wdata = v.wdata[7:0];
      end
      for (int k = 1; k <= ACC_CYC + 1; k++) begin
         @(negedge clk);
         checkOutput({v.name, ".busy"}, 32'(busy), 32'd1);
         checkOutput({v.name, ".addr"}, 32'(mem_addr), 32'(v.addr));
         if (v.chkDi) checkOutput({v.name, ".di"}, 32'(mem_di), 32'(v.expDi));
         if (k <= ACC_CYC) begin
            checkOutput({v.name, ".oe"}, 32'(mem_oe), 32'(v.expOe));
            checkOutput({v.name, ".we_lo"}, 32'(mem_we_lo), 32'(v.expWeLo && (k < ACC_CYC)));
            checkOutput({v.name, ".we_hi"}, 32'(mem_we_hi), 32'(v.expWeHi && (k < ACC_CYC)));
            checkOutput({v.name, ".md_ack_early"}, 32'(md_ack), 32'd0);
            checkOutput({v.name, ".pi_ack_early"}, 32'(pi_ack), 32'd0);
         end else begin
            checkOutput({v.name, ".rec_strobes"}, 32'({mem_oe, mem_we_lo, mem_we_hi}), 32'd0);
            checkOutput({v.name, ".md_ack"}, 32'(md_ack), 32'(v.isMd));
            checkOutput({v.name, ".pi_ack"}, 32'(pi_ack), 32'(!v.isMd));
            if (v.expOe) begin
               if (v.isMd) expMdRdata = v.expRdata;
               else expPiRdata = v.expRdata[7:0];
            end
            checkOutput({v.name, ".md_rdata"}, 32'(md_rdata), 32'(expMdRdata));
            checkOutput({v.name, ".pi_rdata"}, 32'(pi_rdata), 32'(expPiRdata));
            md_req = 1'b0;
            pi_req = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput({v.name, ".idle_busy"}, 32'(busy), 32'd0);
      checkOutput({v.name, ".idle_acks"}, 32'({md_ack, pi_ack}), 32'd0);
      checkOutput({v.name, ".idle_strobes"}, 32'({mem_oe, mem_we_lo, mem_we_hi}), 32'd0);
      checkOutput({v.name, ".idle_addr"}, 32'(mem_addr), 32'(v.addr));
   endtask

   initial begin
      nChecks    = 0;
      nFails     = 0;
      expMdRdata = '0;
      expPiRdata = '0;
      rst_n      = 1'b0;
      md_req     = 1'b0;
      md_addr    = '0;
      md_we_lo   = 1'b0;
      md_we_hi   = 1'b0;
      md_wdata   = '0;
      pi_req     = 1'b0;
      pi_addr    = '0;
      pi_we      = 1'b0;
      pi_wdata   = '0;
      mem_do     = '0;

      //       name      isMd addr        wLo   wHi   piWe  wdata     memDo     chkDi expDi     oe    eLo   eHi   rdata
      tbl[0] = '{"mdRd",   1'b1, 23'h000042, 1'b0, 1'b0, 1'b0, 16'h5555, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF};
      tbl[1] = '{"mdWrHi", 1'b1, 23'h000100, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[2] = '{"mdWrW",  1'b1, 23'h000002, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h0000};
      tbl[3] = '{"piWrLo", 1'b0, 23'h000201, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'hFFFF, 1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h0000};
      tbl[4] = '{"piRdLo", 1'b0, 23'h000201, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h12C3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h00C3};
      tbl[5] = '{"piRdHi", 1'b0, 23'h000200, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h12C3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0012};
      tbl[6] = '{"piWrHi", 1'b0, 23'h000200, 1'b0, 1'b0, 1'b1, 16'h003C, 16'h7777, 1'b1, 16'h3C3C, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[7] = '{"mdRdTop",1'b1, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0F0F, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0F0F};
      tbl[8] = '{"mdWrLo", 1'b1, 23'h000033, 1'b1, 1'b0, 1'b0, 16'h9876, 16'h4444, 1'b1, 16'h9876, 1'b0, 1'b1, 1'b0, 16'h0000};

      // Outputs while held in reset.
      repeat (3) @(negedge clk);
      checkOutput("rst.outs", 32'({md_ack, pi_ack, mem_oe, mem_we_lo, mem_we_hi, busy}), 32'd0);
      checkOutput("rst.addr", 32'(mem_addr), 32'd0);
      checkOutput("rst.rdata", 32'({md_rdata, pi_rdata}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst.idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(tbl[i]);
      end

      // Reset asserted in the middle of a write: strobes must drop immediately.
      @(negedge clk);
      md_req   = 1'b1;
      md_addr  = 23'h000500;
      md_we_lo = 1'b1;
      md_we_hi = 1'b1;
      md_wdata = 16'hCAFE;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstMid.pre_we", 32'({mem_we_lo, mem_we_hi}), 32'h3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstMid.strobes", 32'({mem_oe, mem_we_lo, mem_we_hi}), 32'd0);
      checkOutput("rstMid.busy", 32'(busy), 32'd0);
      checkOutput("rstMid.addr", 32'(mem_addr), 32'd0);
      checkOutput("rstMid.rdata", 32'({md_rdata, pi_rdata}), 32'd0);
      expMdRdata = '0;
      expPiRdata = '0;
      md_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checkOutput("rstMid.no_ack", 32'({md_ack, pi_ack}), 32'd0);
         checkOutput("rstMid.no_busy", 32'(busy), 32'd0);
      end

      // Both requesters hold requests: 8 MD grants then one forced PI grant.
      md_addr  = 23'h000010;
      md_we_lo = 1'b0;
      md_we_hi = 1'b0;
      pi_addr  = 23'h000011;
      pi_we    = 1'b0;
      mem_do   = 16'h5A69;
      md_req   = 1'b1;
      pi_req   = 1'b1;
      for (int n = 1; n <= 18 * PERIOD - 1; n++) begin
         int  g;
         logic ackCyc;
         logic piTurn;
         @(negedge clk);
         g      = n / PERIOD;
         ackCyc = ((n % PERIOD) == PERIOD - 1);
         piTurn = ((g % (MD_MAX + 1)) == MD_MAX);
         checkOutput("fair.md_ack", 32'(md_ack), 32'(ackCyc && !piTurn));
         checkOutput("fair.pi_ack", 32'(pi_ack), 32'(ackCyc && piTurn));
         checkOutput("fair.busy", 32'(busy), 32'((n % PERIOD) != 0));
         if (ackCyc && !piTurn) checkOutput("fair.md_rdata", 32'(md_rdata), 32'h5A69);
         if (ackCyc && piTurn) checkOutput("fair.pi_rdata", 32'(pi_rdata), 32'h69);
      end
      md_req = 1'b0;
      pi_req = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("fair.end_busy", 32'(busy), 32'd0);

      // MD repeats its read; PI arrives mid-access and is served afterwards.
      md_addr = 23'h000020;
      pi_addr = 23'h000301;
      mem_do  = 16'h1111;
      md_req  = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         @(negedge clk);
         checkOutput("b2b.md_ack", 32'(md_ack), 32'((n == 5) || (n == 11)));
         checkOutput("b2b.pi_ack", 32'(pi_ack), 32'(n == 17));
         if (n == 7) checkOutput("b2b.second_oe", 32'(mem_oe), 32'd1);
         if (n == 5) checkOutput("b2b.rdata1", 32'(md_rdata), 32'h1111);
         if (n == 11) checkOutput("b2b.rdata2", 32'(md_rdata), 32'h2222);
         if (n >= 13 && n <= 16) checkOutput("b2b.pi_addr", 32'(mem_addr), 32'h000301);
         if (n == 17) checkOutput("b2b.pi_rdata", 32'(pi_rdata), 32'h44);
         if (n == 6) mem_do = 16'h2222;
         if (n == 8) pi_req = 1'b1;
         if (n == 11) md_req = 1'b0;
         if (n == 12) mem_do = 16'h3344;
         if (n == 17) pi_req = 1'b0;
      end
      checkOutput("b2b.end_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
